mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle MIPS control FSM. Sits directly upstream of the multicycle datapath.
//  Each cycle it decodes IR opcode/funct and the ALU zero flag, then drives every datapath select and strobe.
//  Moore machine: outputs are a combinational function of the current state register plus latched IR fields.
// PARAMETERS
//  ALU_ADD  3'b010  alu_ctrl code for add
//  ALU_SUB  3'b110  alu_ctrl code for subtract
//  ALU_AND  3'b000  alu_ctrl code for and
//  ALU_OR   3'b001  alu_ctrl code for or
//  ALU_SLT  3'b111  alu_ctrl code for set-less-than
// PORTS
//  clk            in   1  clock, rising edge
//  rst            in   1  asynchronous, active-low reset
//  opcode         in   6  IR[31:26] from datapath IR register
//  funct          in   6  IR[5:0] from datapath IR register
//  alu_zero       in   1  ALU zero flag from datapath
//  branch_zero    out  1  to datapath zero_in: alu_zero for beq, ~alu_zero for bne, else 0
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load qualified by branch_zero
//  pc_src         out  2  00 alu_out, 01 jump target, 10 ALUOut, 11 A (jr)
//  IorD           out  1  memory address: 0 PC, 1 ALUOut
//  mem_read       out  1  memory read strobe
//  mem_write      out  1  memory write strobe (data = B)
//  ir_write       out  1  IR load
//  reg_dst        out  2  00 rt, 01 rd; 10 reserved, never driven
//  mem_to_reg     out  1  writeback data: 0 ALUOut, 1 MDR
//  reg_write      out  1  register-file write
//  alu_src_a      out  1  0 PC, 1 A
//  alu_src_b      out  2  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//  alu_ctrl       out  3  ALU operation, codes per PARAMETERS
//  instr_done     out  1  1-cycle pulse in the last state of each instruction
//  illegal_op     out  1  1-cycle pulse in DECODE on an unsupported opcode/funct
//  state_dbg      out  4  current state encoding
// BEHAVIOUR
//  Reset (rst=0, async): state<=IDLE(0). All outputs are 0 while in IDLE. Release -> FETCH on next edge.
//  Unlisted outputs are 0 in every state.
//  FETCH(1): mem_read, ir_write, pc_write, IorD=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00 -> DECODE.
//  DECODE(2): alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
//    lw 100011/sw 101011 -> MEM_ADR
//    R-type 000000: funct 001000 (jr) -> JR; add/sub/and/or/slt (100000/100010/100100/100101/101010) -> R_EXEC
//    beq 000100/bne 000101 -> BRANCH; addi 001000/slti 001010 -> I_EXEC; j 000010 -> JUMP
//    any other opcode or funct -> FETCH with illegal_op=1; no architectural writes occur.
//  MEM_ADR(3): alu_src_a=1, alu_src_b=10, ADD -> MEM_RD (lw) or MEM_WR (sw).
//  MEM_RD(4): IorD=1, mem_read -> MEM_WB.
//  MEM_WB(5): reg_dst=00, mem_to_reg=1, reg_write, instr_done -> FETCH.
//  MEM_WR(6): IorD=1, mem_write, instr_done -> FETCH.
//  R_EXEC(7): alu_src_a=1, alu_src_b=00, alu_ctrl from funct -> R_WB.
//  R_WB(8): reg_dst=01, mem_to_reg=0, reg_write, instr_done -> FETCH.
//  BRANCH(9): alu_src_a=1, alu_src_b=00, SUB, pc_write_cond, pc_src=10; branch_zero per opcode; instr_done -> FETCH.
//  I_EXEC(10): alu_src_a=1, alu_src_b=10; ADD for addi, SLT for slti -> I_WB.
//  I_WB(11): reg_dst=00, mem_to_reg=0, reg_write, instr_done -> FETCH.
//  JUMP(12): pc_write, pc_src=01, instr_done -> FETCH.
//  JR(13): pc_write, pc_src=11, instr_done -> FETCH.
//  Encodings 14-15 are unreachable; if entered, go to FETCH on the next edge with all outputs 0.
//  Cycles per instruction, FETCH inclusive: lw 5; sw, R, addi, slti 4; beq, bne, j, jr 3; illegal 2.
//  Opcode and funct are sampled only in DECODE, R_EXEC, BRANCH, I_EXEC and MEM_ADR. IR is stable there.
//  Reset asserted mid-instruction: abort immediately, no pending write completes, restart at IDLE.
// TESTING
//  Reset: hold rst=0 for 3 cycles, release -> state_dbg 0 then 1; all strobes 0 during reset.
//  lw (opcode 100011): state sequence 1,2,3,4,5; MEM_WB has reg_write=1, mem_to_reg=1; instr_done pulses once.
//  R add (funct 100000) -> R_EXEC alu_ctrl=010, R_WB reg_dst=01. Repeat with slt (101010) -> alu_ctrl=111.
//  beq with alu_zero=1 -> branch_zero=1, pc_write_cond=1. bne with alu_zero=1 -> branch_zero=0.
//  j -> JUMP pc_src=01, pc_write=1. jr (R, funct 001000) -> JR pc_src=11. Each is 3 cycles.
//  opcode 111111 -> illegal_op pulses in DECODE, next state FETCH, no reg_write/mem_write seen.
//  Assert rst in MEM_WR -> mem_write drops asynchronously, state 0.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle MIPS control FSM and its datapath.
// The master side is the controller. It reads the IR fields and the zero flag and drives every select and strobe.
interface mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       branch_zero;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       IorD;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct, alu_zero,
    output branch_zero, pc_write, pc_write_cond, pc_src, IorD, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
           instr_done, illegal_op, state_dbg
  );
  modport slave (
    output opcode, funct, alu_zero,
    input  branch_zero, pc_write, pc_write_cond, pc_src, IorD, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
           instr_done, illegal_op, state_dbg
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM (Moore). The outputs decode the state register plus the IR fields held by the datapath.
// alu_zero is used combinationally for the branch condition.
module mc_controller #(
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b110,
  parameter logic [2:0] ALU_AND = 3'b000,
  parameter logic [2:0] ALU_OR  = 3'b001,
  parameter logic [2:0] ALU_SLT = 3'b111
) (
  input  logic              clk,
  input  logic              rst,
  mc_controller_if.master   bus
);
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADR = 4'd3, S_MEM_RD = 4'd4,
    S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_R_EXEC = 4'd7, S_R_WB = 4'd8, S_BRANCH = 4'd9,
    S_I_EXEC = 4'd10, S_I_WB = 4'd11, S_JUMP = 4'd12, S_JR = 4'd13
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_SLTI = 6'b001010, OP_J = 6'b000010;
  localparam logic [5:0] F_JR = 6'b001000, F_ADD = 6'b100000, F_SUB = 6'b100010,
                         F_AND = 6'b100100, F_OR = 6'b100101, F_SLT = 6'b101010;

  state_t state_q, state_d, dec_nxt;

  // An unsupported opcode or funct sends DECODE back to FETCH.
  always_comb begin
    dec_nxt = S_FETCH;
    case (bus.opcode)
      OP_LW, OP_SW:     dec_nxt = S_MEM_ADR;
      OP_BEQ, OP_BNE:   dec_nxt = S_BRANCH;
      OP_ADDI, OP_SLTI: dec_nxt = S_I_EXEC;
      OP_J:             dec_nxt = S_JUMP;
      OP_R: begin
        case (bus.funct)
          F_JR:                             dec_nxt = S_JR;
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: dec_nxt = S_R_EXEC;
          default:                          dec_nxt = S_FETCH;
        endcase
      end
      default: dec_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = dec_nxt;
      S_MEM_ADR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = S_MEM_WB;
      S_R_EXEC:  state_d = S_R_WB;
      S_I_EXEC:  state_d = S_I_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    bus.branch_zero   = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = 2'b00;
    bus.IorD          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 2'b00;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_ctrl      = ALU_AND;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1; bus.ir_write = 1'b1; bus.pc_write = 1'b1;
        bus.alu_src_b = 2'b01; bus.alu_ctrl = ALU_ADD;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11; bus.alu_ctrl = ALU_ADD;
        bus.illegal_op = (dec_nxt == S_FETCH);
      end
      S_MEM_ADR: begin
        bus.alu_src_a = 1'b1; bus.alu_src_b = 2'b10; bus.alu_ctrl = ALU_ADD;
      end
      S_MEM_RD: begin
        bus.IorD = 1'b1; bus.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        bus.mem_to_reg = 1'b1; bus.reg_write = 1'b1; bus.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        bus.IorD = 1'b1; bus.mem_write = 1'b1; bus.instr_done = 1'b1;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        case (bus.funct)
          F_SUB:   bus.alu_ctrl = ALU_SUB;
          F_AND:   bus.alu_ctrl = ALU_AND;
          F_OR:    bus.alu_ctrl = ALU_OR;
          F_SLT:   bus.alu_ctrl = ALU_SLT;
          default: bus.alu_ctrl = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        bus.reg_dst = 2'b01; bus.reg_write = 1'b1; bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1; bus.alu_ctrl = ALU_SUB;
        bus.pc_write_cond = 1'b1; bus.pc_src = 2'b10; bus.instr_done = 1'b1;
        bus.branch_zero = (bus.opcode == OP_BNE) ? ~bus.alu_zero : bus.alu_zero;
      end
      S_I_EXEC: begin
        bus.alu_src_a = 1'b1; bus.alu_src_b = 2'b10;
        bus.alu_ctrl = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB: begin
        bus.reg_write = 1'b1; bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1; bus.pc_src = 2'b01; bus.instr_done = 1'b1;
      end
      S_JR: begin
        bus.pc_write = 1'b1; bus.pc_src = 2'b11; bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle vector table of {IR, zero, expected state, expected outputs}
// plus hand sequences for reset hold and reset aborting a store.
module tb_mc_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  mc_controller_if bus();

  mc_controller dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // {bz, pcw, pcwc, pc_src[2], IorD, mr, mw, irw, reg_dst[2], m2r, rw, asa, asb[2], alu[3], done, ill}
  logic [20:0] obs;
  assign obs = {bus.branch_zero, bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.IorD,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.instr_done,
                bus.illegal_op};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  st;
    logic [20:0] out;
  } vec_t;

  localparam logic [20:0] O_IDLE   = 21'b0_0_0_00_0_0_0_0_00_0_0_0_00_000_0_0;
  localparam logic [20:0] O_FETCH  = 21'b0_1_0_00_0_1_0_1_00_0_0_0_01_010_0_0;
  localparam logic [20:0] O_DEC    = 21'b0_0_0_00_0_0_0_0_00_0_0_0_11_010_0_0;
  localparam logic [20:0] O_DECILL = 21'b0_0_0_00_0_0_0_0_00_0_0_0_11_010_0_1;
  localparam logic [20:0] O_MADR   = 21'b0_0_0_00_0_0_0_0_00_0_0_1_10_010_0_0;
  localparam logic [20:0] O_MRD    = 21'b0_0_0_00_1_1_0_0_00_0_0_0_00_000_0_0;
  localparam logic [20:0] O_MWB    = 21'b0_0_0_00_0_0_0_0_00_1_1_0_00_000_1_0;
  localparam logic [20:0] O_MWR    = 21'b0_0_0_00_1_0_1_0_00_0_0_0_00_000_1_0;
  localparam logic [20:0] O_RADD   = 21'b0_0_0_00_0_0_0_0_00_0_0_1_00_010_0_0;
  localparam logic [20:0] O_RSLT   = 21'b0_0_0_00_0_0_0_0_00_0_0_1_00_111_0_0;
  localparam logic [20:0] O_ROR    = 21'b0_0_0_00_0_0_0_0_00_0_0_1_00_001_0_0;
  localparam logic [20:0] O_RWB    = 21'b0_0_0_00_0_0_0_0_01_0_1_0_00_000_1_0;
  localparam logic [20:0] O_BR1    = 21'b1_0_1_10_0_0_0_0_00_0_0_1_00_110_1_0;
  localparam logic [20:0] O_BR0    = 21'b0_0_1_10_0_0_0_0_00_0_0_1_00_110_1_0;
  localparam logic [20:0] O_IADD   = 21'b0_0_0_00_0_0_0_0_00_0_0_1_10_010_0_0;
  localparam logic [20:0] O_ISLT   = 21'b0_0_0_00_0_0_0_0_00_0_0_1_10_111_0_0;
  localparam logic [20:0] O_IWB    = 21'b0_0_0_00_0_0_0_0_00_0_1_0_00_000_1_0;
  localparam logic [20:0] O_J      = 21'b0_1_0_01_0_0_0_0_00_0_0_0_00_000_1_0;
  localparam logic [20:0] O_JR     = 21'b0_1_0_11_0_0_0_0_00_0_0_0_00_000_1_0;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic v(input logic [5:0] op, input logic [5:0] fn, input logic z,
                   input logic [3:0] st, input logic [20:0] out);
    vec_t r;
    r.op = op; r.fn = fn; r.z = z; r.st = st; r.out = out;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.alu_zero = 1'b0;

    // lw, 5 cycles
    v(6'b100011, 6'd0, 0, 4'd1, O_FETCH); v(6'b100011, 6'd0, 0, 4'd2, O_DEC);
    v(6'b100011, 6'd0, 0, 4'd3, O_MADR);  v(6'b100011, 6'd0, 0, 4'd4, O_MRD);
    v(6'b100011, 6'd0, 0, 4'd5, O_MWB);
    // R add / slt / or
    v(6'd0, 6'b100000, 0, 4'd1, O_FETCH); v(6'd0, 6'b100000, 0, 4'd2, O_DEC);
    v(6'd0, 6'b100000, 0, 4'd7, O_RADD);  v(6'd0, 6'b100000, 0, 4'd8, O_RWB);
    v(6'd0, 6'b101010, 0, 4'd1, O_FETCH); v(6'd0, 6'b101010, 0, 4'd2, O_DEC);
    v(6'd0, 6'b101010, 0, 4'd7, O_RSLT);  v(6'd0, 6'b101010, 0, 4'd8, O_RWB);
    v(6'd0, 6'b100101, 0, 4'd1, O_FETCH); v(6'd0, 6'b100101, 0, 4'd2, O_DEC);
    v(6'd0, 6'b100101, 0, 4'd7, O_ROR);   v(6'd0, 6'b100101, 0, 4'd8, O_RWB);
    // sw, 4 cycles
    v(6'b101011, 6'd0, 0, 4'd1, O_FETCH); v(6'b101011, 6'd0, 0, 4'd2, O_DEC);
    v(6'b101011, 6'd0, 0, 4'd3, O_MADR);  v(6'b101011, 6'd0, 0, 4'd6, O_MWR);
    // beq/bne with both zero values
    v(6'b000100, 6'd0, 1, 4'd1, O_FETCH); v(6'b000100, 6'd0, 1, 4'd2, O_DEC);
    v(6'b000100, 6'd0, 1, 4'd9, O_BR1);
    v(6'b000101, 6'd0, 1, 4'd1, O_FETCH); v(6'b000101, 6'd0, 1, 4'd2, O_DEC);
    v(6'b000101, 6'd0, 1, 4'd9, O_BR0);
    v(6'b000100, 6'd0, 0, 4'd1, O_FETCH); v(6'b000100, 6'd0, 0, 4'd2, O_DEC);
    v(6'b000100, 6'd0, 0, 4'd9, O_BR0);
    v(6'b000101, 6'd0, 0, 4'd1, O_FETCH); v(6'b000101, 6'd0, 0, 4'd2, O_DEC);
    v(6'b000101, 6'd0, 0, 4'd9, O_BR1);
    // j, jr
    v(6'b000010, 6'd0, 0, 4'd1, O_FETCH); v(6'b000010, 6'd0, 0, 4'd2, O_DEC);
    v(6'b000010, 6'd0, 0, 4'd12, O_J);
    v(6'd0, 6'b001000, 0, 4'd1, O_FETCH); v(6'd0, 6'b001000, 0, 4'd2, O_DEC);
    v(6'd0, 6'b001000, 0, 4'd13, O_JR);
    // addi, slti
    v(6'b001000, 6'd0, 0, 4'd1, O_FETCH); v(6'b001000, 6'd0, 0, 4'd2, O_DEC);
    v(6'b001000, 6'd0, 0, 4'd10, O_IADD); v(6'b001000, 6'd0, 0, 4'd11, O_IWB);
    v(6'b001010, 6'd0, 0, 4'd1, O_FETCH); v(6'b001010, 6'd0, 0, 4'd2, O_DEC);
    v(6'b001010, 6'd0, 0, 4'd10, O_ISLT); v(6'b001010, 6'd0, 0, 4'd11, O_IWB);
    // illegal opcode, then illegal R funct: 2 cycles each
    v(6'b111111, 6'd0, 0, 4'd1, O_FETCH); v(6'b111111, 6'd0, 0, 4'd2, O_DECILL);
    v(6'd0, 6'b000001, 0, 4'd1, O_FETCH); v(6'd0, 6'b000001, 0, 4'd2, O_DECILL);
    v(6'b100011, 6'd0, 0, 4'd1, O_FETCH);

    // reset held for 3 cycles: idle state, all strobes low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_state", 32'(bus.state_dbg), 32'd0);
      check("rst_outs", 32'(obs), 32'(O_IDLE));
    end
    rst = 1'b1;
    #1;
    check("rel_state", 32'(bus.state_dbg), 32'd0);
    check("rel_outs", 32'(obs), 32'(O_IDLE));

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.opcode = tbl[i].op; bus.funct = tbl[i].fn; bus.alu_zero = tbl[i].z;
      #1;
      check($sformatf("vec%0d_state", i), 32'(bus.state_dbg), 32'(tbl[i].st));
      check($sformatf("vec%0d_outs", i), 32'(obs), 32'(tbl[i].out));
    end

    // reset mid-store: mem_write must drop at once, no clock edge needed
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.opcode = 6'b101011; bus.funct = 6'd0;
    begin
      int cyc;
      cyc = 0;
      while (bus.state_dbg !== 4'd6 && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      check("wait_mem_wr", 32'(bus.state_dbg), 32'd6);
    end
    check("mw_before_rst", 32'(bus.mem_write), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mw_after_rst", 32'(bus.mem_write), 32'd0);
    check("state_after_rst", 32'(bus.state_dbg), 32'd0);
    check("outs_after_rst", 32'(obs), 32'(O_IDLE));
    @(negedge clk);
    check("held_in_rst", 32'(bus.state_dbg), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
